tile_addr_gen: RTL and testbench
================================

TILE_ADDR_GEN -- requirements
Module: tile_addr_gen

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, address width in elements.
REQ-002 SHALL have parameter IDX_WIDTH, default 8, width of sizes, strides and loop counters.
REQ-003 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start_tile  input  1  one-cycle request to begin generating addresses for one tile.
REQ-006 tile_ready  output  1  high when a start_tile will be accepted.
REQ-007 tile_done  output  1  one-cycle pulse when all addresses for the tile have been transferred.
REQ-008 baseA_tile, baseB_tile, baseC_tile  input  ADDR_WIDTH each  tile base addresses.
REQ-009 eTM, eTN, eTK  input  IDX_WIDTH each  effective tile sizes.
REQ-010 K, N  input  IDX_WIDTH each  row strides: A rows use K; B and C rows use N.
REQ-011 addr_out  output  ADDR_WIDTH  generated element address.
REQ-012 addr_sel  output  2  operand tag: 0=A read, 1=B read, 2=C write; 3 is unused.
REQ-013 addr_last  output  1  high on the final beat of the current phase.
REQ-014 addr_valid  output  1  addr_out, addr_sel and addr_last are valid.
REQ-015 addr_ready  input  1  consumer accepts the beat.

Function
REQ-016 SHALL implement states IDLE, GEN_A, GEN_B, GEN_C, DONE.
REQ-017 tile_ready SHALL be 1 only in IDLE; start_tile in any other state SHALL be ignored.
REQ-018 On start_tile in IDLE, the block SHALL register all base, size and stride inputs; later input changes SHALL have no effect until the next accepted start.
REQ-019 If any of eTM, eTN, eTK is 0 at acceptance, the next state SHALL be DONE and no beat SHALL be issued; otherwise the next state SHALL be GEN_A.
REQ-020 First addr_valid SHALL assert in the cycle after acceptance.
REQ-021 GEN_A SHALL issue, for i in 0..eTM-1 (outer) and k in 0..eTK-1 (inner): baseA + i*K + k.
REQ-022 GEN_B SHALL issue, for k in 0..eTK-1 (outer) and j in 0..eTN-1 (inner): baseB + k*N + j.
REQ-023 GEN_C SHALL issue, for i in 0..eTM-1 (outer) and j in 0..eTN-1 (inner): baseC + i*N + j.
REQ-024 A beat SHALL transfer only when addr_valid && addr_ready; while addr_valid=1 and addr_ready=0, outputs SHALL hold stable.
REQ-025 The transfer with addr_last=1 SHALL move the block GEN_A->GEN_B, GEN_B->GEN_C, or GEN_C->DONE, with no bubble between phases.
REQ-026 DONE SHALL last exactly one cycle, assert tile_done, and then return to IDLE.
REQ-027 addr_valid SHALL be 0 in IDLE and DONE.
REQ-028 Addresses SHALL be formed incrementally: a row pointer plus stride, and a column offset.
REQ-029 The block SHALL contain no multipliers.
REQ-030 Address arithmetic SHALL wrap modulo 2^ADDR_WIDTH.
REQ-031 Counters SHALL be IDX_WIDTH bits wide; a size of 2^IDX_WIDTH-1 SHALL be supported without overflow.
REQ-032 Beat count per tile SHALL be eTM*eTK + eTK*eTN + eTM*eTN.

Reset
REQ-033 On rst, the state SHALL be IDLE.
REQ-034 On rst, all counters and registered inputs SHALL be 0.
REQ-035 On rst, the outputs SHALL be: addr_valid=0, tile_done=0, addr_out=0, addr_sel=0, addr_last=0, tile_ready=1 after release.
REQ-036 A reset mid-tile SHALL abandon the tile without a tile_done pulse.

Structure
REQ-037 Package matmul_agu_pkg SHALL hold the state enum agu_state_t and the addr_sel constants SEL_A, SEL_B, SEL_C.
REQ-038 Sub-module tile_loop_counter SHALL implement a 2-D nested counter with row-pointer/stride stepping and a last flag.
REQ-039 tile_loop_counter SHALL be instantiated once and reloaded per phase.

Verification
REQ-040 Scenario A, addr_ready=1: baseA=0x100, K=4, eTM=2, eTK=3 -> A beats 0x100, 0x101, 0x102, 0x104, 0x105, 0x106, with last on 0x106.
REQ-041 Scenario B, same tile: baseB=0x200, N=5, eTN=2 -> B beats 0x200, 0x201, 0x205, 0x206, 0x20A, 0x20B; then baseC=0x300 -> C beats 0x300, 0x301, 0x305, 0x306; tile_done exactly 1 cycle after the 0x306 transfer; 16 beats total.
REQ-042 Scenario C, backpressure: random addr_ready at 50% -> same address sequence as A/B; outputs stable while stalled.
REQ-043 Scenario D, zero size: eTN=0 -> no addr_valid; tile_done in the cycle after acceptance + 1; tile_ready returns 1.
REQ-044 Scenario E, robustness: start_tile pulsed during GEN_B -> ignored; rst asserted during GEN_C -> outputs reset immediately, no tile_done.
REQ-045 Scenario F, wrap: baseA=0xFFFFFFFE, K=1, eTM=1, eTK=4 -> A beats 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.

Source files
------------

// File: rtl/matmul_agu_pkg.sv
// Shared types for the matmul address generation unit: FSM state encoding
// and operand tags carried on addr_sel.
package matmul_agu_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GEN_A = 3'd1,
        GEN_B = 3'd2,
        GEN_C = 3'd3,
        DONE  = 3'd4
    } agu_state_t;

    localparam logic [1:0] SEL_A = 2'd0;
    localparam logic [1:0] SEL_B = 2'd1;
    localparam logic [1:0] SEL_C = 2'd2;

endpackage

// File: rtl/tile_loop_counter.sv
// Two-level nested address counter: the inner loop walks consecutive elements,
// the outer loop advances a row pointer by a stride. No multipliers involved.
module tile_loop_counter #(
    parameter int ADDR_WIDTH = 32,
    parameter int IDX_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  step,
    input  logic [ADDR_WIDTH-1:0] base,
    input  logic [IDX_WIDTH-1:0]  stride,
    input  logic [IDX_WIDTH-1:0]  outer_size,
    input  logic [IDX_WIDTH-1:0]  inner_size,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  last
);

    localparam logic [IDX_WIDTH-1:0]  IDX_ONE  = IDX_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] addr_r;
    logic [ADDR_WIDTH-1:0] row_ptr_r;
    logic [IDX_WIDTH-1:0]  stride_r;
    logic [IDX_WIDTH-1:0]  outer_m1_r;
    logic [IDX_WIDTH-1:0]  inner_m1_r;
    logic [IDX_WIDTH-1:0]  row_r;
    logic [IDX_WIDTH-1:0]  col_r;
    logic                  last_r;

    logic                  col_end_s;
    logic [IDX_WIDTH-1:0]  next_row_s;
    logic [IDX_WIDTH-1:0]  next_col_s;
    logic [ADDR_WIDTH-1:0] next_ptr_s;
    logic [ADDR_WIDTH-1:0] next_addr_s;
    logic                  next_last_s;

    // Next position in the nest; counters compare against size-1 so a
    // size of all-ones never needs a wider counter.
    always_comb begin
        col_end_s   = (col_r == inner_m1_r);
        next_row_s  = row_r;
        next_col_s  = col_r + IDX_ONE;
        next_ptr_s  = row_ptr_r;
        next_addr_s = addr_r + ADDR_ONE;
        if (col_end_s) begin
            next_row_s  = row_r + IDX_ONE;
            next_col_s  = '0;
            next_ptr_s  = row_ptr_r + ADDR_WIDTH'(stride_r);
            next_addr_s = row_ptr_r + ADDR_WIDTH'(stride_r);
        end else begin
            next_row_s  = row_r;
        end
        next_last_s = (next_row_s == outer_m1_r) && (next_col_s == inner_m1_r);
    end

    // Loop state: load restarts the nest at base, step advances one element.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_r     <= '0;
            row_ptr_r  <= '0;
            stride_r   <= '0;
            outer_m1_r <= '0;
            inner_m1_r <= '0;
            row_r      <= '0;
            col_r      <= '0;
            last_r     <= 1'b0;
        end else if (load) begin
            addr_r     <= base;
            row_ptr_r  <= base;
            stride_r   <= stride;
            outer_m1_r <= outer_size - IDX_ONE;
            inner_m1_r <= inner_size - IDX_ONE;
            row_r      <= '0;
            col_r      <= '0;
            last_r     <= (outer_size == IDX_ONE) && (inner_size == IDX_ONE);
        end else if (step) begin
            addr_r     <= next_addr_s;
            row_ptr_r  <= next_ptr_s;
            row_r      <= next_row_s;
            col_r      <= next_col_s;
            last_r     <= next_last_s;
        end
    end

    assign addr = addr_r;
    assign last = last_r;

endmodule

// File: rtl/tile_addr_gen.sv
// Tile address generator: streams A reads, B reads, then C writes for one
// matmul tile over a valid/ready port, using a single reloadable loop counter.
module tile_addr_gen
    import matmul_agu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int IDX_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_tile,
    output logic                  tile_ready,
    output logic                  tile_done,
    input  logic [ADDR_WIDTH-1:0] baseA_tile,
    input  logic [ADDR_WIDTH-1:0] baseB_tile,
    input  logic [ADDR_WIDTH-1:0] baseC_tile,
    input  logic [IDX_WIDTH-1:0]  eTM,
    input  logic [IDX_WIDTH-1:0]  eTN,
    input  logic [IDX_WIDTH-1:0]  eTK,
    input  logic [IDX_WIDTH-1:0]  K,
    input  logic [IDX_WIDTH-1:0]  N,
    output logic [ADDR_WIDTH-1:0] addr_out,
    output logic [1:0]            addr_sel,
    output logic                  addr_last,
    input  logic                  addr_ready,
    output logic                  addr_valid
);

    agu_state_t            state_r;
    logic [ADDR_WIDTH-1:0] base_b_r;
    logic [ADDR_WIDTH-1:0] base_c_r;
    logic [IDX_WIDTH-1:0]  etm_r;
    logic [IDX_WIDTH-1:0]  etn_r;
    logic [IDX_WIDTH-1:0]  etk_r;
    logic [IDX_WIDTH-1:0]  n_r;
    logic                  addr_valid_r;
    logic [1:0]            addr_sel_r;
    logic                  tile_done_r;
    logic                  tile_ready_r;

    logic                  transfer_s;
    logic                  zero_s;
    logic                  load_s;
    logic                  step_s;
    logic [ADDR_WIDTH-1:0] ld_base_s;
    logic [IDX_WIDTH-1:0]  ld_stride_s;
    logic [IDX_WIDTH-1:0]  ld_outer_s;
    logic [IDX_WIDTH-1:0]  ld_inner_s;
    logic [ADDR_WIDTH-1:0] cnt_addr_s;
    logic                  cnt_last_s;

    assign transfer_s = addr_valid_r && addr_ready;
    assign zero_s     = (eTM == '0) || (eTN == '0) || (eTK == '0);

    // Counter control: the phase-ending transfer reloads the counter for the
    // next operand in the same cycle, so phases run back to back.
    always_comb begin
        load_s      = 1'b0;
        step_s      = 1'b0;
        ld_base_s   = baseA_tile;
        ld_stride_s = K;
        ld_outer_s  = eTM;
        ld_inner_s  = eTK;
        case (state_r)
            IDLE: begin
                if (start_tile && !zero_s) begin
                    load_s = 1'b1;
                end else begin
                    load_s = 1'b0;
                end
            end
            GEN_A: begin
                if (transfer_s && cnt_last_s) begin
                    load_s      = 1'b1;
                    ld_base_s   = base_b_r;
                    ld_stride_s = n_r;
                    ld_outer_s  = etk_r;
                    ld_inner_s  = etn_r;
                end else begin
                    step_s = transfer_s;
                end
            end
            GEN_B: begin
                if (transfer_s && cnt_last_s) begin
                    load_s      = 1'b1;
                    ld_base_s   = base_c_r;
                    ld_stride_s = n_r;
                    ld_outer_s  = etm_r;
                    ld_inner_s  = etn_r;
                end else begin
                    step_s = transfer_s;
                end
            end
            GEN_C: begin
                if (transfer_s && !cnt_last_s) begin
                    step_s = 1'b1;
                end else begin
                    step_s = 1'b0;
                end
            end
            default: begin
                load_s = 1'b0;
                step_s = 1'b0;
            end
        endcase
    end

    tile_loop_counter #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_loop (
        .clk        (clk),
        .rst        (rst),
        .load       (load_s),
        .step       (step_s),
        .base       (ld_base_s),
        .stride     (ld_stride_s),
        .outer_size (ld_outer_s),
        .inner_size (ld_inner_s),
        .addr       (cnt_addr_s),
        .last       (cnt_last_s)
    );

    // Tile sequencing FSM with registered handshake and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            base_b_r     <= '0;
            base_c_r     <= '0;
            etm_r        <= '0;
            etn_r        <= '0;
            etk_r        <= '0;
            n_r          <= '0;
            addr_valid_r <= 1'b0;
            addr_sel_r   <= SEL_A;
            tile_done_r  <= 1'b0;
            tile_ready_r <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    tile_done_r <= 1'b0;
                    if (start_tile) begin
                        base_b_r     <= baseB_tile;
                        base_c_r     <= baseC_tile;
                        etm_r        <= eTM;
                        etn_r        <= eTN;
                        etk_r        <= eTK;
                        n_r          <= N;
                        tile_ready_r <= 1'b0;
                        if (zero_s) begin
                            state_r     <= DONE;
                            tile_done_r <= 1'b1;
                        end else begin
                            state_r      <= GEN_A;
                            addr_valid_r <= 1'b1;
                            addr_sel_r   <= SEL_A;
                        end
                    end else begin
                        tile_ready_r <= 1'b1;
                    end
                end
                GEN_A: begin
                    if (transfer_s && cnt_last_s) begin
                        state_r    <= GEN_B;
                        addr_sel_r <= SEL_B;
                    end
                end
                GEN_B: begin
                    if (transfer_s && cnt_last_s) begin
                        state_r    <= GEN_C;
                        addr_sel_r <= SEL_C;
                    end
                end
                GEN_C: begin
                    if (transfer_s && cnt_last_s) begin
                        state_r      <= DONE;
                        addr_valid_r <= 1'b0;
                        tile_done_r  <= 1'b1;
                    end
                end
                DONE: begin
                    state_r      <= IDLE;
                    tile_done_r  <= 1'b0;
                    tile_ready_r <= 1'b1;
                end
                default: begin
                    state_r      <= IDLE;
                    addr_valid_r <= 1'b0;
                    tile_done_r  <= 1'b0;
                    tile_ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign addr_out   = cnt_addr_s;
    assign addr_last  = cnt_last_s;
    assign addr_sel   = addr_sel_r;
    assign addr_valid = addr_valid_r;
    assign tile_done  = tile_done_r;
    assign tile_ready = tile_ready_r;

endmodule

// File: tb/tb_tile_addr_gen.sv
// Directed bench for tile_addr_gen: table of tiles, each checked beat by beat
// against hand-computed address lists, with stall, glitch and reset cases.
module tb_tile_addr_gen;
    import matmul_agu_pkg::*;

    localparam int AW = 32;
    localparam int IW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_tile;
    logic          tile_ready;
    logic          tile_done;
    logic [AW-1:0] baseA_tile, baseB_tile, baseC_tile;
    logic [IW-1:0] eTM, eTN, eTK, K, N;
    logic [AW-1:0] addr_out;
    logic [1:0]    addr_sel;
    logic          addr_last;
    logic          addr_ready;
    logic          addr_valid;

    always #5 clk = ~clk;

    tile_addr_gen #(.ADDR_WIDTH(AW), .IDX_WIDTH(IW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_tile (start_tile),
        .tile_ready (tile_ready),
        .tile_done  (tile_done),
        .baseA_tile (baseA_tile),
        .baseB_tile (baseB_tile),
        .baseC_tile (baseC_tile),
        .eTM        (eTM),
        .eTN        (eTN),
        .eTK        (eTK),
        .K          (K),
        .N          (N),
        .addr_out   (addr_out),
        .addr_sel   (addr_sel),
        .addr_last  (addr_last),
        .addr_ready (addr_ready),
        .addr_valid (addr_valid)
    );

    typedef struct {
        logic [1:0]    sel;
        logic [AW-1:0] addr;
        logic          last;
    } beat_t;

    typedef struct {
        logic [AW-1:0] ba, bb, bc;
        logic [IW-1:0] m, n, k, ks, ns;
    } cfg_t;

    typedef struct {
        int cfg;
        int first;
        int nbeats;
        int pct;
        int glitch;
        int abort;
    } test_t;

    beat_t exp_beats [25];
    cfg_t  cfgs [3];
    test_t tests [6];
    int    checks = 0;
    int    errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic drive_cfg(input cfg_t c);
        baseA_tile = c.ba;
        baseB_tile = c.bb;
        baseC_tile = c.bc;
        eTM = c.m;
        eTN = c.n;
        eTK = c.k;
        K   = c.ks;
        N   = c.ns;
    endtask

    task automatic set_beat(input int i, input logic [1:0] s, input logic [AW-1:0] a, input logic l);
        exp_beats[i].sel  = s;
        exp_beats[i].addr = a;
        exp_beats[i].last = l;
    endtask

    task automatic run_test(input test_t t);
        int            got;
        int            cyc;
        bit            stalled;
        bit            aborted;
        logic [AW-1:0] p_addr;
        logic [1:0]    p_sel;
        logic          p_last;
        beat_t         e;
        got = 0;
        cyc = 0;
        stalled = 1'b0;
        aborted = 1'b0;
        p_addr = '0;
        p_sel = 2'd0;
        p_last = 1'b0;
        @(negedge clk);
        drive_cfg(cfgs[t.cfg]);
        start_tile = 1'b1;
        addr_ready = 1'b0;
        @(negedge clk);
        start_tile = 1'b0;
        // Scramble inputs: the accepted tile must not see these.
        drive_cfg(cfgs[(t.cfg + 1) % 3]);
        check("ready_low_after_start", tile_ready, 1'b0);
        if (t.nbeats == 0) begin
            check("zero_valid", addr_valid, 1'b0);
            check("zero_done", tile_done, 1'b1);
            @(negedge clk);
            check("zero_done_clear", tile_done, 1'b0);
            check("zero_ready", tile_ready, 1'b1);
            check("zero_valid_after", addr_valid, 1'b0);
            return;
        end
        check("first_valid", addr_valid, 1'b1);
        while (got < t.nbeats && cyc < 2000 && !aborted) begin
            if (t.abort >= 0 && got == t.abort) begin
                rst = 1'b1;
                #1;
                check("abort_valid", addr_valid, 1'b0);
                check("abort_addr", addr_out, 32'h0);
                check("abort_sel", addr_sel, 2'd0);
                check("abort_last", addr_last, 1'b0);
                check("abort_done", tile_done, 1'b0);
                repeat (2) @(negedge clk);
                rst = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    check("abort_no_done", tile_done, 1'b0);
                end
                check("abort_ready", tile_ready, 1'b1);
                aborted = 1'b1;
            end else begin
                start_tile = (t.glitch >= 0 && got == t.glitch);
                addr_ready = ($urandom_range(99) < t.pct);
                if (stalled) begin
                    check("stall_valid", addr_valid, 1'b1);
                    check("stall_addr", addr_out, p_addr);
                    check("stall_sel", addr_sel, p_sel);
                    check("stall_last", addr_last, p_last);
                end
                check("no_early_done", tile_done, 1'b0);
                if (addr_valid && addr_ready) begin
                    e = exp_beats[t.first + got];
                    check("beat_sel", addr_sel, e.sel);
                    check("beat_addr", addr_out, e.addr);
                    check("beat_last", addr_last, e.last);
                    got++;
                end
                stalled = addr_valid && !addr_ready;
                p_addr = addr_out;
                p_sel = addr_sel;
                p_last = addr_last;
                @(negedge clk);
                cyc++;
            end
        end
        start_tile = 1'b0;
        addr_ready = 1'b0;
        if (aborted) return;
        if (got < t.nbeats) begin
            check("beat_timeout", got, t.nbeats);
        end else begin
            check("end_valid", addr_valid, 1'b0);
            check("end_done", tile_done, 1'b1);
            @(negedge clk);
            check("end_done_clear", tile_done, 1'b0);
            check("end_ready", tile_ready, 1'b1);
        end
    endtask

    initial begin
        // Tile A/B/C: 2x3 A (K=4), 3x2 B (N=5), 2x2 C (N=5).
        set_beat(0,  SEL_A, 32'h100, 1'b0);
        set_beat(1,  SEL_A, 32'h101, 1'b0);
        set_beat(2,  SEL_A, 32'h102, 1'b0);
        set_beat(3,  SEL_A, 32'h104, 1'b0);
        set_beat(4,  SEL_A, 32'h105, 1'b0);
        set_beat(5,  SEL_A, 32'h106, 1'b1);
        set_beat(6,  SEL_B, 32'h200, 1'b0);
        set_beat(7,  SEL_B, 32'h201, 1'b0);
        set_beat(8,  SEL_B, 32'h205, 1'b0);
        set_beat(9,  SEL_B, 32'h206, 1'b0);
        set_beat(10, SEL_B, 32'h20A, 1'b0);
        set_beat(11, SEL_B, 32'h20B, 1'b1);
        set_beat(12, SEL_C, 32'h300, 1'b0);
        set_beat(13, SEL_C, 32'h301, 1'b0);
        set_beat(14, SEL_C, 32'h305, 1'b0);
        set_beat(15, SEL_C, 32'h306, 1'b1);
        // Wrap tile: 1x4 A from 0xFFFFFFFE, 4x1 B, 1x1 C.
        set_beat(16, SEL_A, 32'hFFFFFFFE, 1'b0);
        set_beat(17, SEL_A, 32'hFFFFFFFF, 1'b0);
        set_beat(18, SEL_A, 32'h0, 1'b0);
        set_beat(19, SEL_A, 32'h1, 1'b1);
        set_beat(20, SEL_B, 32'h10, 1'b0);
        set_beat(21, SEL_B, 32'h11, 1'b0);
        set_beat(22, SEL_B, 32'h12, 1'b0);
        set_beat(23, SEL_B, 32'h13, 1'b1);
        set_beat(24, SEL_C, 32'h20, 1'b1);

        cfgs[0] = '{ba: 32'h100, bb: 32'h200, bc: 32'h300, m: 8'd2, n: 8'd2, k: 8'd3, ks: 8'd4, ns: 8'd5};
        cfgs[1] = '{ba: 32'hFFFFFFFE, bb: 32'h10, bc: 32'h20, m: 8'd1, n: 8'd1, k: 8'd4, ks: 8'd1, ns: 8'd1};
        cfgs[2] = '{ba: 32'h400, bb: 32'h500, bc: 32'h600, m: 8'd2, n: 8'd0, k: 8'd3, ks: 8'd7, ns: 8'd9};

        tests[0] = '{cfg: 0, first: 0,  nbeats: 16, pct: 100, glitch: -1, abort: -1};
        tests[1] = '{cfg: 0, first: 0,  nbeats: 16, pct: 50,  glitch: -1, abort: -1};
        tests[2] = '{cfg: 1, first: 16, nbeats: 9,  pct: 100, glitch: -1, abort: -1};
        tests[3] = '{cfg: 2, first: 0,  nbeats: 0,  pct: 100, glitch: -1, abort: -1};
        tests[4] = '{cfg: 0, first: 0,  nbeats: 16, pct: 100, glitch: 7,  abort: 14};
        tests[5] = '{cfg: 0, first: 0,  nbeats: 16, pct: 100, glitch: -1, abort: -1};

        rst = 1'b1;
        start_tile = 1'b0;
        addr_ready = 1'b0;
        drive_cfg(cfgs[0]);
        #1;
        check("rst_valid", addr_valid, 1'b0);
        check("rst_done", tile_done, 1'b0);
        check("rst_addr", addr_out, 32'h0);
        check("rst_sel", addr_sel, 2'd0);
        check("rst_last", addr_last, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", tile_ready, 1'b1);

        for (int i = 0; i < 6; i++) begin
            run_test(tests[i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
